// File: rtl/cnn_pkg.sv
// Shared types and defaults for the conv feature-map datapath.
// Contents:
//   DATA_W_DEF / ADDR_W_DEF : default word and address widths
//   rd_mode_e               : read-back order (raster or 2x2 window)
//   rd_state_e              : read engine sequencer states
package cnn_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;

    typedef enum logic {
        RD_RASTER = 1'b0,
        RD_WIN    = 1'b1
    } rd_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry valid/ready buffer between the RAM read data and the stream output.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid, in_data     : push side (no ready; the producer never pushes into a full buffer)
//   out_valid, out_ready  : pop side handshake
//   out_data              : head entry, held stable until popped
//   occ                   : current occupancy (0..2)
module rd_skid_buf #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);

    logic [W-1:0] ent0;
    logic [W-1:0] ent1;
    logic [1:0]   cnt;
    logic         pop;

    assign pop       = out_valid & out_ready;
    assign out_valid = (cnt != 2'd0);
    assign out_data  = ent0;
    assign occ       = cnt;

    // ent0 is always the head; ent1 only holds data when two entries are queued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent0 <= '0;
            ent1 <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({in_valid, pop})
                2'b10: begin
                    if (cnt == 2'd0) ent0 <= in_data;
                    else             ent1 <= in_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        ent0 <= ent1;
                        ent1 <= in_data;
                    end else begin
                        ent0 <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fmap_ram_reader.sv
// Feature-map RAM read engine: walks a ROWS x COLS map from base_addr, issues
// one-cycle-latency reads and streams the words out in raster or 2x2-window order.
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   start, win_mode, base_addr     : pass launch (sampled in IDLE only)
//   ram_addr, ram_re, ram_q        : RAM read port (data on ram_q the cycle after ram_re)
//   m_valid, m_ready, m_data       : output stream
//   m_last, m_win_last             : final beat / 4th beat of a 2x2 window
//   busy, done                     : pass in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads under the buffer credit limit
// DRAIN | all addresses issued, waiting for the last beat to be accepted
// DONE  | one-cycle done pulse, busy low
module fmap_ram_reader
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ROWS   = 28,
    parameter int COLS   = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              win_mode,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_q,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_win_last,
    output logic              busy,
    output logic              done
);

    localparam int N_RASTER = ROWS * COLS;
    localparam int N_WIN    = 4 * (ROWS / 2) * (COLS / 2);
    localparam int CNT_W    = $clog2(N_RASTER + 1);
    localparam int WC_W     = ((COLS / 2) > 1) ? $clog2(COLS / 2) : 1;

    localparam logic [CNT_W-1:0]  LAST_RASTER = CNT_W'(N_RASTER - 1);
    localparam logic [CNT_W-1:0]  LAST_WIN    = CNT_W'(N_WIN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [WC_W-1:0]   WC_MAX      = WC_W'((COLS / 2) - 1);
    localparam logic [WC_W-1:0]   WC_ONE      = WC_W'(1);
    localparam logic [ADDR_W-1:0] A_ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TWO       = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_COLS      = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] A_COLS1     = ADDR_W'(COLS + 1);
    localparam logic [ADDR_W-1:0] A_ROW2      = ADDR_W'(2 * COLS);

    rd_state_e         state;
    rd_state_e         state_nxt;
    rd_mode_e          mode;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] win_base;
    logic [WC_W-1:0]   wc;
    logic [1:0]        sub;
    logic [CNT_W-1:0]  cnt;
    logic              primed;
    logic              rd_pend;
    logic              rd_last;
    logic              rd_wl;
    logic [1:0]        occ;
    logic              pop;
    logic              credit;
    logic              issue;
    logic              issue_last;
    logic              issue_wl;
    logic [DATA_W+1:0] head;

    assign pop = m_valid & m_ready;

    // Words already owed to the buffer (stored + the one on ram_q) minus the one
    // leaving this cycle must leave room for the read issued now.
    assign credit     = ({1'b0, occ} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop});
    assign issue_last = (cnt == ((mode == RD_WIN) ? LAST_WIN : LAST_RASTER));
    assign issue_wl   = (mode == RD_WIN) && (sub == 2'd3);

    assign ram_re   = issue;
    assign ram_addr = addr_q;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy  = 1'b1;
                // First RUN cycle only loads the address walker; reads start after it.
                issue = primed & credit;
                if (issue && issue_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && m_last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            mode     <= RD_RASTER;
            addr_q   <= '0;
            row_base <= '0;
            win_base <= '0;
            wc       <= '0;
            sub      <= 2'd0;
            cnt      <= '0;
            primed   <= 1'b0;
            rd_pend  <= 1'b0;
            rd_last  <= 1'b0;
            rd_wl    <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_pend <= issue;
            rd_last <= issue & issue_last;
            rd_wl   <= issue & issue_wl;
            if (state == IDLE && start) begin
                mode     <= rd_mode_e'(win_mode);
                addr_q   <= base_addr;
                row_base <= base_addr;
                win_base <= base_addr;
                wc       <= '0;
                sub      <= 2'd0;
                cnt      <= '0;
                primed   <= 1'b0;
            end else if (state == RUN) begin
                primed <= 1'b1;
                // After the final issue the address is left alone so ram_addr holds.
                if (issue && !issue_last) begin
                    cnt <= cnt + CNT_ONE;
                    if (mode == RD_RASTER) begin
                        addr_q <= addr_q + A_ONE;
                    end else begin
                        sub <= sub + 2'd1;
                        case (sub)
                            2'd0: addr_q <= win_base + A_ONE;
                            2'd1: addr_q <= win_base + A_COLS;
                            2'd2: addr_q <= win_base + A_COLS1;
                            default: begin
                                if (wc == WC_MAX) begin
                                    wc       <= '0;
                                    row_base <= row_base + A_ROW2;
                                    win_base <= row_base + A_ROW2;
                                    addr_q   <= row_base + A_ROW2;
                                end else begin
                                    wc       <= wc + WC_ONE;
                                    win_base <= win_base + A_TWO;
                                    addr_q   <= win_base + A_TWO;
                                end
                            end
                        endcase
                    end
                end
            end
        end
    end

    rd_skid_buf #(.W(DATA_W + 2)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_pend),
        .in_data   ({ram_q, rd_last, rd_wl}),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (head),
        .occ       (occ)
    );

    assign m_data     = head[DATA_W+1:2];
    assign m_last     = head[1];
    assign m_win_last = head[0];

endmodule

// File: tb/tb_fmap_ram_reader.sv
module tb_fmap_ram_reader;

    logic        clk = 1'b0;
    logic        rst_n, start, win_mode, m_ready;
    logic [15:0] base_addr;
    bit          sel;

    logic [15:0] ram_addr4, ram_q4, m_data4, ram_addr5, ram_q5, m_data5;
    logic        ram_re4, m_valid4, m_last4, m_wl4, busy4, done4;
    logic        ram_re5, m_valid5, m_last5, m_wl5, busy5, done5;
    logic        start4, start5;

    assign start4 = start & ~sel;
    assign start5 = start & sel;

    fmap_ram_reader #(.DATA_W(16), .ADDR_W(16), .ROWS(4), .COLS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .win_mode(win_mode), .base_addr(base_addr),
        .ram_addr(ram_addr4), .ram_re(ram_re4), .ram_q(ram_q4), .m_valid(m_valid4),
        .m_ready(m_ready), .m_data(m_data4), .m_last(m_last4), .m_win_last(m_wl4),
        .busy(busy4), .done(done4));

    fmap_ram_reader #(.DATA_W(16), .ADDR_W(16), .ROWS(5), .COLS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .win_mode(win_mode), .base_addr(base_addr),
        .ram_addr(ram_addr5), .ram_re(ram_re5), .ram_q(ram_q5), .m_valid(m_valid5),
        .m_ready(m_ready), .m_data(m_data5), .m_last(m_last5), .m_win_last(m_wl5),
        .busy(busy5), .done(done5));

    always #5 clk = ~clk;

    // RAM contents: mem[a] = 3*a, one-cycle read latency
    always @(posedge clk) begin
        if (ram_re4) ram_q4 <= 16'(3 * ram_addr4);
        if (ram_re5) ram_q5 <= 16'(3 * ram_addr5);
    end

    logic [15:0] o_addr, o_data;
    logic        o_re, o_valid, o_last, o_wl, o_busy, o_done;
    assign o_addr  = sel ? ram_addr5 : ram_addr4;
    assign o_re    = sel ? ram_re5   : ram_re4;
    assign o_data  = sel ? m_data5   : m_data4;
    assign o_valid = sel ? m_valid5  : m_valid4;
    assign o_last  = sel ? m_last5   : m_last4;
    assign o_wl    = sel ? m_wl5     : m_wl4;
    assign o_busy  = sel ? busy5     : busy4;
    assign o_done  = sel ? done5     : done4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Behavioural model: expected address and beat sequences for a pass
    logic [15:0] exp_addr[$];
    logic [15:0] exp_d[$];
    logic        exp_l[$];
    logic        exp_w[$];

    task automatic load_model(input bit win, input logic [15:0] base, input int rows, input int cols);
        logic [15:0] a;
        int n;
        exp_addr.delete(); exp_d.delete(); exp_l.delete(); exp_w.delete();
        if (!win) begin
            for (int r = 0; r < rows; r++)
                for (int c = 0; c < cols; c++) begin
                    a = 16'(base + r * cols + c);
                    exp_addr.push_back(a);
                end
        end else begin
            for (int wr = 0; wr < rows / 2; wr++)
                for (int wc = 0; wc < cols / 2; wc++)
                    for (int k = 0; k < 4; k++) begin
                        a = 16'(base + (2 * wr + k / 2) * cols + 2 * wc + k % 2);
                        exp_addr.push_back(a);
                    end
        end
        n = exp_addr.size();
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(16'(3 * exp_addr[i]));
            exp_l.push_back(i == n - 1);
            exp_w.push_back(win && (i % 4 == 3));
        end
    endtask

    int          issued, accepted, done_cnt, pass_beats, pass_addrs;
    int          start_cyc, first_acc_cyc, last_acc_cyc;
    bit          first_seen, prev_stall;
    logic [15:0] prev_d;
    logic        prev_l, prev_w;
    logic [15:0] addr_log[64];
    logic [15:0] data_log[64];
    logic        wl_log[64];

    initial begin
        issued = 0; accepted = 0; done_cnt = 0; pass_beats = 0; pass_addrs = 0;
        start_cyc = 0; first_acc_cyc = 0; last_acc_cyc = 0;
        first_seen = 1'b1; prev_stall = 1'b0;
    end

    // Compare process: outputs checked against the model every cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_addr.delete(); exp_d.delete(); exp_l.delete(); exp_w.delete();
            issued = 0; accepted = 0; prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", o_valid, 1'b1);
                chk("hold_data", o_data, prev_d);
                chk("hold_last", o_last, prev_l);
                chk("hold_wlast", o_wl, prev_w);
            end
            if (o_re) begin
                chk("outstanding_le2",
                    ((issued - accepted) + 1 - ((o_valid && m_ready) ? 1 : 0)) <= 2, 1'b1);
                chk("ram_read_expected", exp_addr.size() > 0, 1'b1);
                if (exp_addr.size() > 0) chk("ram_addr", o_addr, exp_addr.pop_front());
                if (pass_addrs < 64) addr_log[pass_addrs] = o_addr;
                pass_addrs++;
            end
            if (o_valid && !first_seen) begin
                first_seen = 1'b1;
                chk("first_valid_latency", cyc - start_cyc, 3);
            end
            if (o_valid && m_ready) begin
                chk("beat_expected", exp_d.size() > 0, 1'b1);
                if (exp_d.size() > 0) begin
                    chk("m_data", o_data, exp_d.pop_front());
                    chk("m_last", o_last, exp_l.pop_front());
                    chk("m_win_last", o_wl, exp_w.pop_front());
                end
                if (pass_beats < 64) begin
                    data_log[pass_beats] = o_data;
                    wl_log[pass_beats]   = o_wl;
                end
                if (pass_beats == 0) first_acc_cyc = cyc;
                pass_beats++;
                if (o_last) last_acc_cyc = cyc;
            end
            if (o_done) begin
                done_cnt++;
                chk("busy_low_in_done", o_busy, 1'b0);
                chk("beats_left_at_done", exp_d.size(), 0);
                chk("done_after_last", cyc - last_acc_cyc, 1);
            end
            issued   += o_re ? 1 : 0;
            accepted += (o_valid && m_ready) ? 1 : 0;
            prev_stall = o_valid && !m_ready;
            prev_d = o_data; prev_l = o_last; prev_w = o_wl;
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic do_start(input bit s, input bit win, input logic [15:0] base, input int dim);
        sel = s;
        win_mode = win;
        base_addr = base;
        load_model(win, base, dim, dim);
        pass_beats = 0; pass_addrs = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = cyc;
        first_seen = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_cnt != d0) break;
        end
        chk(name, done_cnt - d0, 1);
    endtask

    logic [15:0] t2_addr[16];
    logic        rdy_pat[9];
    int          d0;
    int          rr, cc;

    initial begin
        rst_n = 1'b0; start = 1'b0; win_mode = 1'b0; base_addr = 16'h0; m_ready = 1'b1; sel = 1'b0;
        repeat (3) step();
        chk("rst_ram_addr", o_addr, 16'h0);
        chk("rst_ram_re", o_re, 1'b0);
        chk("rst_m_valid", o_valid, 1'b0);
        chk("rst_m_data", o_data, 16'h0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        rst_n = 1'b1;
        step();

        // 1: raster 4x4, full throughput
        do_start(1'b0, 1'b0, 16'h0000, 4);
        chk("t1_busy_high", o_busy, 1'b1);
        wait_done("t1_done", 200);
        chk("t1_beats", pass_beats, 16);
        chk("t1_back_to_back", last_acc_cyc - first_acc_cyc, 15);
        chk("t1_beat1", data_log[0], 16'd0);
        chk("t1_beat2", data_log[1], 16'd3);
        chk("t1_beat16", data_log[15], 16'd45);
        step();

        // 2: window 4x4 from 0x0010
        t2_addr = '{16'd16, 16'd17, 16'd20, 16'd21, 16'd18, 16'd19, 16'd22, 16'd23,
                    16'd24, 16'd25, 16'd28, 16'd29, 16'd26, 16'd27, 16'd30, 16'd31};
        do_start(1'b0, 1'b1, 16'h0010, 4);
        wait_done("t2_done", 200);
        chk("t2_addr_count", pass_addrs, 16);
        for (int i = 0; i < 16; i++) chk("t2_addr_order", addr_log[i], t2_addr[i]);
        for (int i = 0; i < 16; i++) chk("t2_win_last", wl_log[i], (i % 4) == 3);
        step();

        // 3: raster with backpressure
        rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_start(1'b0, 1'b0, 16'h0000, 4);
        repeat (3) step();
        for (int i = 0; i < 9; i++) begin
            m_ready = rdy_pat[i];
            step();
        end
        m_ready = 1'b1;
        wait_done("t3_done", 200);
        chk("t3_beats", pass_beats, 16);
        for (int i = 0; i < 16; i++) chk("t3_seq", data_log[i], 16'(3 * i));
        step();

        // 4: address wrap, mid-pass start ignored
        d0 = done_cnt;
        do_start(1'b0, 1'b0, 16'hFFFE, 4);
        repeat (4) step();
        start = 1'b1; base_addr = 16'h1234; win_mode = 1'b1;
        step();
        start = 1'b0;
        wait_done("t4_done", 200);
        repeat (10) step();
        chk("t4_single_done", done_cnt - d0, 1);
        chk("t4_beats", pass_beats, 16);
        chk("t4_addr0", addr_log[0], 16'hFFFE);
        chk("t4_addr1", addr_log[1], 16'hFFFF);
        chk("t4_addr2", addr_log[2], 16'h0000);
        chk("t4_addr15", addr_log[15], 16'h000D);

        // 5: reset mid-pass, then a fresh pass
        do_start(1'b0, 1'b0, 16'h0000, 4);
        for (int i = 0; i < 200 && pass_beats < 7; i++) step();
        chk("t5_reached_beat7", pass_beats >= 7, 1'b1);
        d0 = done_cnt;
        rst_n = 1'b0;
        step();
        chk("t5_ram_addr", o_addr, 16'h0);
        chk("t5_ram_re", o_re, 1'b0);
        chk("t5_m_valid", o_valid, 1'b0);
        chk("t5_m_data", o_data, 16'h0);
        chk("t5_m_last", o_last, 1'b0);
        chk("t5_m_win_last", o_wl, 1'b0);
        chk("t5_busy", o_busy, 1'b0);
        chk("t5_done", o_done, 1'b0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("t5_no_done", done_cnt - d0, 0);
        do_start(1'b0, 1'b0, 16'h0000, 4);
        wait_done("t5_replay_done", 200);
        chk("t5_replay_beats", pass_beats, 16);
        chk("t5_replay_first", data_log[0], 16'd0);
        step();

        // 6: window on a 5x5 map, last row/col skipped
        do_start(1'b1, 1'b1, 16'h0000, 5);
        wait_done("t6_done", 200);
        chk("t6_beats", pass_beats, 16);
        chk("t6_addrs", pass_addrs, 16);
        for (int i = 0; i < 16; i++) begin
            rr = int'(addr_log[i]) / 5;
            cc = int'(addr_log[i]) % 5;
            chk("t6_inside_4x4", (rr < 4) && (cc < 4), 1'b1);
        end
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
